// File: rtl/z80_loader_pkg.sv
// Shared definitions for the Z80 program loader: parser state encoding,
// command codes and the default frame start byte.
// No logic; imported by the loader top and its testbench.
package z80_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_AL   = 3'd2,
    ST_AH   = 3'd3,
    ST_LL   = 3'd4,
    ST_LH   = 3'd5,
    ST_DATA = 3'd6,
    ST_SUM  = 3'd7
  } ld_state_t;

  localparam logic [7:0] CMD_WRITE     = 8'h00;
  localparam logic [7:0] CMD_WRITE_RUN = 8'h01;
  localparam logic [7:0] CMD_RUN       = 8'h02;
  localparam logic [7:0] CMD_HALT      = 8'h03;

  localparam logic [7:0] SYNC_DEFAULT  = 8'hA5;

  // Commands that carry a payload and hold the core while it is written.
  function automatic logic cmd_is_write(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_WRITE_RUN);
  endfunction

endpackage

// File: rtl/z80_loader_if.sv
// Bus bundle between the UART receiver / Z80 core side and the loader.
// Carries the RX byte strobe, the core memory bus, the RAM bus and status.
// master: drives RX and core signals; slave: the loader itself.
interface z80_loader_if;
  logic        RX_VALID;
  logic [7:0]  RX_DATA;
  logic [15:0] CPU_A;
  logic [7:0]  CPU_DO;
  logic        CPU_W;
  logic        HOLD;
  logic [15:0] MEM_A;
  logic [7:0]  MEM_D;
  logic        MEM_W;
  logic        BUSY;
  logic        ERR;

  modport master (
    output RX_VALID, RX_DATA, CPU_A, CPU_DO, CPU_W,
    input  HOLD, MEM_A, MEM_D, MEM_W, BUSY, ERR
  );

  modport slave (
    input  RX_VALID, RX_DATA, CPU_A, CPU_DO, CPU_W,
    output HOLD, MEM_A, MEM_D, MEM_W, BUSY, ERR
  );
endinterface

// File: rtl/z80_mem_mux.sv
// RAM bus select: core bus when hold=1, loader registers when hold=0.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the switch takes effect in the same cycle hold changes.
// Ports: hold select, cpu_* core bus, ld_* loader bus, mem_* RAM bus.
module z80_mem_mux (
  input  logic        hold,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_w,
  input  logic [15:0] ld_a,
  input  logic [7:0]  ld_d,
  input  logic        ld_w,
  output logic [15:0] mem_a,
  output logic [7:0]  mem_d,
  output logic        mem_w
);

  always_comb begin
    if (hold) begin
      mem_a = cpu_a;
      mem_d = cpu_do;
      mem_w = cpu_w;
    end else begin
      mem_a = ld_a;
      mem_d = ld_d;
      mem_w = ld_w;
    end
  end

endmodule

// File: rtl/z80_loader.sv
// Program loader / run control: parses SYNC,CMD,AL,AH,LL,LH,DATA*LEN,SUM frames
// and writes payload to RAM while the core is held. Latency: a byte accepted at
// cycle n is written (or changes HOLD) at n+1. Backpressure: none, one byte/cycle.
// Ports: CLOCK, RESET_N (sync, active-low), bus (slave modport of z80_loader_if).
module z80_loader
  import z80_loader_pkg::*;
#(
  parameter logic [7:0] SYNC     = SYNC_DEFAULT,
  parameter int         TIMEOUT  = 1_000_000,
  parameter bit         BOOT_RUN = 1'b0
) (
  input logic         CLOCK,
  input logic         RESET_N,
  z80_loader_if.slave bus
);

  localparam int              TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);

  ld_state_t     state_q, state_d;
  logic [7:0]    cmd_q;
  logic [15:0]   addr_q;
  logic [15:0]   len_q;
  logic [7:0]    sum_q;
  logic [TW-1:0] to_cnt_q;
  logic          hold_q;
  logic          err_q;
  logic [15:0]   wr_a_q;
  logic [7:0]    wr_d_q;
  logic          wr_w_q;

  logic          rx;
  logic [7:0]    rx_b;
  logic [7:0]    sum_nx;
  logic [15:0]   len_full;
  logic          to_expire;
  logic          fail;
  logic          sum_ok;
  logic          busy;

  assign rx       = bus.RX_VALID;
  assign rx_b     = bus.RX_DATA;
  assign sum_nx   = sum_q + rx_b;
  assign len_full = {rx_b, len_q[7:0]};

  // State register.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic plus the per-byte verdicts the datapath acts on.
  always_comb begin
    state_d   = state_q;
    fail      = 1'b0;
    sum_ok    = 1'b0;
    // A byte arriving on the expiry cycle takes priority over the timeout.
    to_expire = (state_q != ST_IDLE) && !rx && (to_cnt_q == TO_LAST);
    if (to_expire) begin
      state_d = ST_IDLE;
      fail    = 1'b1;
    end else if (rx) begin
      unique case (state_q)
        ST_IDLE: if (rx_b == SYNC) state_d = ST_CMD;
        ST_CMD: begin
          if (rx_b > CMD_HALT) begin
            fail    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_AL;
          end
        end
        ST_AL: state_d = ST_AH;
        ST_AH: state_d = ST_LL;
        ST_LL: state_d = ST_LH;
        ST_LH: begin
          if (len_full == 16'd0) begin
            state_d = ST_SUM;
          end else if (!cmd_is_write(cmd_q)) begin
            fail    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
        ST_DATA: if (len_q == 16'd1) state_d = ST_SUM;
        ST_SUM: begin
          sum_ok  = (sum_nx == 8'h00);
          fail    = !sum_ok;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Datapath: checksum, address/length counters, timeout, HOLD/ERR, write strobe.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      cmd_q    <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      sum_q    <= '0;
      to_cnt_q <= '0;
      hold_q   <= BOOT_RUN;
      err_q    <= 1'b0;
      wr_a_q   <= '0;
      wr_d_q   <= '0;
      wr_w_q   <= 1'b0;
    end else begin
      wr_w_q <= 1'b0;

      if (rx || (state_q == ST_IDLE) || to_expire) to_cnt_q <= '0;
      else                                         to_cnt_q <= to_cnt_q + 1'b1;

      if (fail)   err_q <= 1'b1;
      if (sum_ok) err_q <= 1'b0;

      if (rx) begin
        unique case (state_q)
          ST_IDLE: sum_q <= 8'h00;
          ST_CMD: begin
            cmd_q <= rx_b;
            sum_q <= sum_nx;
            // Hold the core before the first payload byte can reach RAM.
            if (cmd_is_write(rx_b)) hold_q <= 1'b0;
          end
          ST_AL: begin
            addr_q[7:0] <= rx_b;
            sum_q       <= sum_nx;
          end
          ST_AH: begin
            addr_q[15:8] <= rx_b;
            sum_q        <= sum_nx;
          end
          ST_LL: begin
            len_q[7:0] <= rx_b;
            sum_q      <= sum_nx;
          end
          ST_LH: begin
            len_q[15:8] <= rx_b;
            sum_q       <= sum_nx;
          end
          ST_DATA: begin
            wr_a_q <= addr_q;
            wr_d_q <= rx_b;
            wr_w_q <= 1'b1;
            addr_q <= addr_q + 16'd1;   // wraps FFFF -> 0000
            len_q  <= len_q - 16'd1;
            sum_q  <= sum_nx;
          end
          ST_SUM: begin
            if (sum_ok) begin
              if (cmd_q == CMD_WRITE_RUN || cmd_q == CMD_RUN) hold_q <= 1'b1;
              else if (cmd_q == CMD_HALT)                     hold_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // The pending strobe is gated by reset so a mid-frame reset never lets it out.
  z80_mem_mux u_mux (
    .hold   (hold_q),
    .cpu_a  (bus.CPU_A),
    .cpu_do (bus.CPU_DO),
    .cpu_w  (bus.CPU_W),
    .ld_a   (wr_a_q),
    .ld_d   (wr_d_q),
    .ld_w   (wr_w_q & RESET_N),
    .mem_a  (bus.MEM_A),
    .mem_d  (bus.MEM_D),
    .mem_w  (bus.MEM_W)
  );

  assign bus.HOLD = hold_q;
  assign bus.BUSY = busy;
  assign bus.ERR  = err_q;

endmodule

// File: tb/tb_z80_loader.sv
// Directed bench for z80_loader: frames, run/halt, wrap, bad sum, timeout, reset.
// Inputs driven 1 time unit after the rising edge; outputs checked there too.
// Expected values are hand-computed from the frame format and checksum rule.
module tb_z80_loader;
  import z80_loader_pkg::*;

  logic CLOCK   = 1'b0;
  logic RESET_N = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  z80_loader_if bus ();

  z80_loader #(
    .SYNC     (8'hA5),
    .TIMEOUT  (16),
    .BOOT_RUN (1'b0)
  ) dut (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.RX_VALID = 1'b1;
    bus.RX_DATA  = b;
    tick();
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
  endtask

  initial begin
    bus.RX_VALID = 1'b0;
    bus.RX_DATA  = 8'h00;
    bus.CPU_A    = 16'h0000;
    bus.CPU_DO   = 8'h00;
    bus.CPU_W    = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_hold", bus.HOLD, 1'b0);
    chk("rst_busy", bus.BUSY, 1'b0);
    chk("rst_err",  bus.ERR,  1'b0);
    chk("rst_memw", bus.MEM_W, 1'b0);
    chk("rst_mema", bus.MEM_A, 16'h0000);
    RESET_N = 1'b1;
    tick();

    // Non-SYNC byte in IDLE is ignored
    send(8'h00);
    chk("idle_ignore_busy", bus.BUSY, 1'b0);

    // WRITE 3 bytes at 8000; checksum 00+00+80+03+00+11+22+33 = E9 -> SUM 17
    send(8'hA5);
    chk("a_busy_after_sync", bus.BUSY, 1'b1);
    send(8'h00); send(8'h00); send(8'h80); send(8'h03); send(8'h00);
    send(8'h11);
    chk("a_w0_w", bus.MEM_W, 1'b1);
    chk("a_w0_a", bus.MEM_A, 16'h8000);
    chk("a_w0_d", bus.MEM_D, 8'h11);
    send(8'h22);
    chk("a_w1_w", bus.MEM_W, 1'b1);
    chk("a_w1_a", bus.MEM_A, 16'h8001);
    chk("a_w1_d", bus.MEM_D, 8'h22);
    send(8'h33);
    chk("a_w2_w", bus.MEM_W, 1'b1);
    chk("a_w2_a", bus.MEM_A, 16'h8002);
    chk("a_w2_d", bus.MEM_D, 8'h33);
    send(8'h17);
    chk("a_strobe_one_cycle", bus.MEM_W, 1'b0);
    chk("a_hold", bus.HOLD, 1'b0);
    chk("a_err",  bus.ERR,  1'b0);
    chk("a_busy_end", bus.BUSY, 1'b0);

    // RUN; core bus is blocked while held, passes through once HOLD rises
    bus.CPU_A  = 16'h1234;
    bus.CPU_DO = 8'h5A;
    bus.CPU_W  = 1'b1;
    send(8'hA5); send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h00);
    chk("run_hold_before_sum", bus.HOLD, 1'b0);
    chk("run_cpu_blocked", bus.MEM_W, 1'b0);
    send(8'hFE);
    chk("run_hold", bus.HOLD, 1'b1);
    chk("run_pass_w", bus.MEM_W, 1'b1);
    chk("run_pass_a", bus.MEM_A, 16'h1234);
    chk("run_pass_d", bus.MEM_D, 8'h5A);

    // WRITE_RUN at FFFF len 2: CMD byte drops HOLD and cuts the core write
    send(8'hA5); send(8'h01);
    chk("wr_cmd_hold", bus.HOLD, 1'b0);
    chk("wr_cmd_cut_w", bus.MEM_W, 1'b0);
    bus.CPU_W = 1'b0;
    send(8'hFF); send(8'hFF); send(8'h02); send(8'h00);
    send(8'hAA);
    chk("wr_w0_a", bus.MEM_A, 16'hFFFF);
    chk("wr_w0_d", bus.MEM_D, 8'hAA);
    chk("wr_w0_w", bus.MEM_W, 1'b1);
    send(8'hBB);
    chk("wr_wrap_a", bus.MEM_A, 16'h0000);
    chk("wr_w1_d", bus.MEM_D, 8'hBB);
    chk("wr_w1_hold_low", bus.HOLD, 1'b0);
    // 01+FF+FF+02+00+AA+BB = 66 -> SUM 9A
    send(8'h9A);
    chk("wr_hold", bus.HOLD, 1'b1);
    chk("wr_err",  bus.ERR,  1'b0);

    // Same frame, bad SUM: data still written, ERR set, HOLD stays 0
    send(8'hA5); send(8'h01); send(8'hFF); send(8'hFF); send(8'h02); send(8'h00);
    send(8'hAA);
    chk("bad_w0_a", bus.MEM_A, 16'hFFFF);
    chk("bad_w0_w", bus.MEM_W, 1'b1);
    send(8'hBB);
    chk("bad_w1_a", bus.MEM_A, 16'h0000);
    chk("bad_w1_d", bus.MEM_D, 8'hBB);
    send(8'h9B);
    chk("bad_err",  bus.ERR,  1'b1);
    chk("bad_hold", bus.HOLD, 1'b0);
    chk("bad_busy", bus.BUSY, 1'b0);

    // Good HALT clears ERR
    send(8'hA5); send(8'h03); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'hFD);
    chk("halt_err",  bus.ERR,  1'b0);
    chk("halt_hold", bus.HOLD, 1'b0);

    // RUN with LEN=1 is rejected at LH
    send(8'hA5); send(8'h02); send(8'h00); send(8'h00); send(8'h01); send(8'h00);
    chk("runlen_err",  bus.ERR,  1'b1);
    chk("runlen_busy", bus.BUSY, 1'b0);
    chk("runlen_hold", bus.HOLD, 1'b0);

    // Clear, then unknown CMD is rejected
    send(8'hA5); send(8'h03); send(8'h00); send(8'h00); send(8'h00); send(8'h00); send(8'hFD);
    chk("halt2_err", bus.ERR, 1'b0);
    send(8'hA5); send(8'h07);
    chk("badcmd_err",  bus.ERR,  1'b1);
    chk("badcmd_busy", bus.BUSY, 1'b0);

    // Byte on the expiry cycle wins; frame (WRITE, LEN 0, SUM 00) completes
    send(8'hA5); send(8'h00);
    repeat (15) tick();
    chk("to_busy_before_expiry", bus.BUSY, 1'b1);
    send(8'h00);
    chk("to_byte_wins_busy", bus.BUSY, 1'b1);
    send(8'h00); send(8'h00); send(8'h00);
    send(8'h00);
    chk("to_frame_done_err",  bus.ERR,  1'b0);
    chk("to_frame_done_busy", bus.BUSY, 1'b0);

    // Stall 16 cycles: frame aborted with ERR
    send(8'hA5); send(8'h00);
    repeat (15) tick();
    chk("to_stall15_busy", bus.BUSY, 1'b1);
    tick();
    chk("to_expire_busy", bus.BUSY, 1'b0);
    chk("to_expire_err",  bus.ERR,  1'b1);
    chk("to_expire_hold", bus.HOLD, 1'b0);

    // Reset one cycle after a DATA byte: no MEM_W pulse, reset values restored
    send(8'hA5); send(8'h00); send(8'h00); send(8'h10); send(8'h02); send(8'h00);
    bus.RX_VALID = 1'b1;
    bus.RX_DATA  = 8'h44;
    tick();
    bus.RX_VALID = 1'b0;
    RESET_N      = 1'b0;
    #1;
    chk("rstmid_no_pulse", bus.MEM_W, 1'b0);
    tick();
    chk("rstmid_memw", bus.MEM_W, 1'b0);
    chk("rstmid_hold", bus.HOLD,  1'b0);
    chk("rstmid_busy", bus.BUSY,  1'b0);
    chk("rstmid_err",  bus.ERR,   1'b0);
    chk("rstmid_mema", bus.MEM_A, 16'h0000);
    chk("rstmid_memd", bus.MEM_D, 8'h00);
    RESET_N = 1'b1;
    tick();
    chk("rstmid_after_memw", bus.MEM_W, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
